ram_arbiter: RTL
================

Name: ram_arbiter

Overview:
- Two-requester round-robin arbiter and sequencer in front of the team's 256x4 single-port synchronous RAM (chip-select, write, read, 8-bit address, 4-bit data).
- Serialises read/write requests from two masters into legal RAM cycles.
- Holds chip-select across the read-data cycle so the RAM output is not cleared before capture.
- Returns read data to the requester that issued the read, with a one-cycle valid pulse.

Parameters:
- ADDR_W, 8: address width; RAM depth is 2**ADDR_W.
- DATA_W, 4: data width.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- req0 / req1  in  1  request; held high until matching ack.
- we0 / we1  in  1  1 = write, 0 = read; stable while req is high.
- addr0 / addr1  in  ADDR_W  access address; stable while req is high.
- wdata0 / wdata1  in  DATA_W  write data; stable while req is high.
- ack0 / ack1  out  1  one-cycle pulse: request accepted.
- rvalid0 / rvalid1  out  1  one-cycle pulse: rdata valid.
- rdata0 / rdata1  out  DATA_W  read data; holds last value between reads.
- mem_cs  out  1  RAM chip select.
- mem_write  out  1  RAM write enable.
- mem_read  out  1  RAM read enable.
- mem_addr  out  ADDR_W  RAM address.
- mem_din  out  DATA_W  RAM write data.
- mem_dout  in  DATA_W  RAM read data; registered inside RAM, cleared when cs is low at a clock edge.

Behaviour:
- Reset (asynchronous, immediate):
  - state=IDLE, last_grant=1.
  - All outputs 0: ack*, rvalid*, rdata*, mem_cs, mem_write, mem_read, mem_addr, mem_din.
  - An in-flight access is discarded. If reset asserts during ACCESS, mem_write drops before the next edge, so no write occurs.
- All outputs are registered; no combinational path from inputs to outputs.
- FSM states: IDLE, ACCESS, RDWAIT.
- IDLE:
  - mem_cs=mem_read=mem_write=0.
  - At an edge with req0|req1: pick winner w.
    - Only one requester active -> that one wins.
    - Both active -> the requester != last_grant wins.
  - Register mem_cs<=1, mem_write<=we_w, mem_read<=~we_w, mem_addr<=addr_w, mem_din<=wdata_w, ack_w<=1, last_grant<=w; go to ACCESS.
- ACCESS: exactly one cycle; the RAM samples the command at the edge that ends it. At that edge:
  - ack_w<=0 and mem_write<=0 in all cases.
  - Write: mem_cs<=0, mem_read<=0; go to IDLE.
  - Read: mem_cs stays 1, mem_read<=0; go to RDWAIT.
- RDWAIT: one cycle; mem_dout is valid. At the edge that ends it: rdata_w<=mem_dout, rvalid_w<=1 (cleared next edge), mem_cs<=0; go to IDLE.
- The request's input values are never sampled outside IDLE. The requester updates req/we/addr/wdata at the edge after seeing ack.
- Timing, request sampled at edge E:
  - ack high E..E+1.
  - RAM acts at E+1.
  - Read: rvalid high E+2..E+3.
- Throughput:
  - Write: next grant at earliest edge E+2.
  - Read: next grant at earliest edge E+3.
- Fairness: with both requesters continuously active, grants alternate 0,1,0,1. No requester waits more than one other access.
- Only the granted requester's rdata/rvalid change; the other side's rdata is untouched.
- Address has no wrap logic; the full ADDR_W range passes through unchanged.

Decomposition:
- Package ram_arb_pkg:
  - state enum (IDLE=2'd0, ACCESS=2'd1, RDWAIT=2'd2).
  - default ADDR_W/DATA_W constants.
  - requester-id constants REQ0=1'b0, REQ1=1'b1.
- One sub-module ram_arb_rr2: combinational 2-way round-robin picker.
  - Inputs: req0, req1, last_grant.
  - Outputs: any, winner.
- FSM, command register, and per-requester read-return registers live in ram_arbiter. Bench pairs ram_arbiter with the 256x4 RAM model.

Test Plan:
- Reset mid-read: assert reset during RDWAIT -> all outputs 0 immediately, no rvalid. After release, state=IDLE and the first simultaneous request grants req0.
- Single write then read:
  - req0 write addr 8'h3C, data 4'hA -> ack0 pulses one cycle, mem_write=1 for one cycle with mem_addr=3C, mem_din=A.
  - req0 read addr 3C -> rvalid0 pulses 2 cycles after ack0, rdata0=4'hA, rdata1 unchanged.
- Simultaneous requests after reset: req0 write 8'h00/4'h5, req1 write 8'hFF/4'hC held -> ack0 first, ack1 at the next grant. Memory then holds 00=5, FF=C.
- Continuous contention: both issue 6 reads of distinct addresses preloaded with 1..6 -> grant order 0,1,0,1,0,1; each rvalid carries its own preloaded data; grant spacing 3 cycles.
- Chip-select hold: on a read, mem_cs stays high through RDWAIT and falls only after rdata captures. Check mem_cs=1 at the capture edge and rdata!=0 for nonzero data.
- Back-to-back writes from req1 alone: 4 writes -> acks spaced exactly 2 cycles; req0 idle -> ack0/rvalid0 never assert.

Source files
------------

// File: rtl/ram_arb_pkg.sv
// ram_arb_pkg: shared state encoding, default widths and requester ids for ram_arbiter
package ram_arb_pkg;
  localparam int ADDR_W_DEF = 8;
  localparam int DATA_W_DEF = 4;
  localparam logic REQ0 = 1'b0;
  localparam logic REQ1 = 1'b1;
  typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, RDWAIT = 2'd2} state_t;
endpackage

// File: rtl/ram_arbiter_if.sv
// ram_arbiter_if: two requester ports plus the RAM command/data bus
//   master: requester/RAM side (drives req/we/addr/wdata per requester and mem_dout)
//   slave : arbiter side (drives ack/rvalid/rdata per requester and the mem_* command)
interface ram_arbiter_if
  import ram_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
);
  logic              req0, req1, we0, we1;
  logic [ADDR_W-1:0] addr0, addr1;
  logic [DATA_W-1:0] wdata0, wdata1;
  logic              ack0, ack1, rvalid0, rvalid1;
  logic [DATA_W-1:0] rdata0, rdata1;
  logic              mem_cs, mem_write, mem_read;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_din, mem_dout;
  modport master (
    output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_dout,
    input  ack0, ack1, rvalid0, rvalid1, rdata0, rdata1,
           mem_cs, mem_write, mem_read, mem_addr, mem_din
  );
  modport slave (
    input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_dout,
    output ack0, ack1, rvalid0, rvalid1, rdata0, rdata1,
           mem_cs, mem_write, mem_read, mem_addr, mem_din
  );
endinterface

// File: rtl/ram_arb_rr2.sv
// ram_arb_rr2: combinational two-way round-robin picker
//   i_req0/i_req1: requests, i_last_grant: previous winner
//   o_any: some request present, o_winner: chosen requester (0/1)
module ram_arb_rr2 (
  input  logic i_req0,
  input  logic i_req1,
  input  logic i_last_grant,
  output logic o_any,
  output logic o_winner
);
  always_comb begin
    o_any    = i_req0 | i_req1;
    o_winner = (i_req0 & i_req1) ? ~i_last_grant : i_req1;
  end
endmodule

// File: rtl/ram_arbiter.sv
// ram_arbiter: round-robin sequencer of two requesters onto a single-port synchronous RAM
//   clk: rising-edge clock, reset: asynchronous active-high
//   bus: requester handshakes (req/we/addr/wdata -> ack/rvalid/rdata) and RAM command bus
module ram_arbiter
  import ram_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input logic          clk,
  input logic          reset,
  ram_arbiter_if.slave bus
);
  state_t            r_state;
  logic              r_last;
  logic [1:0]        r_ack, r_rvalid;
  logic [DATA_W-1:0] r_rdata [2];
  logic              r_cs, r_wr, r_rd;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_din;
  logic              w_any, w_win, w_we;
  logic [ADDR_W-1:0] w_addr;
  logic [DATA_W-1:0] w_wdata;
  ram_arb_rr2 u_rr (
    .i_req0      (bus.req0),
    .i_req1      (bus.req1),
    .i_last_grant(r_last),
    .o_any       (w_any),
    .o_winner    (w_win)
  );
  always_comb begin
    w_we    = (w_win == REQ1) ? bus.we1 : bus.we0;
    w_addr  = (w_win == REQ1) ? bus.addr1 : bus.addr0;
    w_wdata = (w_win == REQ1) ? bus.wdata1 : bus.wdata0;
  end
  // r_wr doubles as the "this access is a write" flag during ACCESS; a read keeps
  // chip-select through RDWAIT so the RAM's registered output survives until capture.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= IDLE;
      r_last     <= REQ1;
      r_ack      <= '0;
      r_rvalid   <= '0;
      r_rdata[0] <= '0;
      r_rdata[1] <= '0;
      r_cs       <= 1'b0;
      r_wr       <= 1'b0;
      r_rd       <= 1'b0;
      r_addr     <= '0;
      r_din      <= '0;
    end else begin
      r_ack    <= '0;
      r_rvalid <= '0;
      case (r_state)
        IDLE: if (w_any) begin
          r_cs         <= 1'b1;
          r_wr         <= w_we;
          r_rd         <= ~w_we;
          r_addr       <= w_addr;
          r_din        <= w_wdata;
          r_ack[w_win] <= 1'b1;
          r_last       <= w_win;
          r_state      <= ACCESS;
        end
        ACCESS: begin
          r_wr    <= 1'b0;
          r_rd    <= 1'b0;
          r_cs    <= ~r_wr;
          r_state <= r_wr ? IDLE : RDWAIT;
        end
        RDWAIT: begin
          r_rdata[r_last]  <= bus.mem_dout;
          r_rvalid[r_last] <= 1'b1;
          r_cs             <= 1'b0;
          r_state          <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
  assign bus.ack0      = r_ack[0];
  assign bus.ack1      = r_ack[1];
  assign bus.rvalid0   = r_rvalid[0];
  assign bus.rvalid1   = r_rvalid[1];
  assign bus.rdata0    = r_rdata[0];
  assign bus.rdata1    = r_rdata[1];
  assign bus.mem_cs    = r_cs;
  assign bus.mem_write = r_wr;
  assign bus.mem_read  = r_rd;
  assign bus.mem_addr  = r_addr;
  assign bus.mem_din   = r_din;
endmodule
